// File: rtl/weight_monitor_pkg.sv
// Shared types and default constants for the cabin weight monitor.
package weight_pkg;

  typedef enum logic {
    NORMAL   = 1'b0,
    OVERLOAD = 1'b1
  } weight_state_t;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_CAPACITY   = 5;
  localparam int DEF_HYST       = 1;
  localparam int DEF_ALARM_HALF = 4;

endpackage

// File: rtl/weight_monitor_rise_detect.sv
// Rising-edge detector: the pulse is combinational against a registered
// previous sample, so an edge acts on the same clock edge that samples it.
module rise_detect (
  input  logic clk,
  input  logic button_reset,
  input  logic clear,
  input  logic in,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values, independent of statement order.
    if (button_reset || clear) prev_q <= 1'b0;
    else                       prev_q <= in;
  end

  assign pulse = in & ~prev_q;

endmodule

// File: rtl/weight_monitor.sv
// Up/down cabin load counter with hysteretic overload flag and door hold.
// Optional blinking overload alarm is enabled by defining WEIGHT_ALARM_EN.
module weight_monitor
  import weight_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int CAPACITY   = DEF_CAPACITY,
  parameter int HYST       = DEF_HYST,
  parameter int ALARM_HALF = DEF_ALARM_HALF
) (
  input  logic             clk,
  input  logic             button_reset,
  input  logic             door,
  input  logic             weight_inc,
  input  logic             weight_dec,
  input  logic             weight_flip_reset,
  output logic [CNT_W-1:0] load_count,
  output logic             near_full,
  output logic             weight_limit_exceeded,
  output logic             door_hold,
  output logic             alarm
);

  localparam logic [CNT_W-1:0] MAX_COUNT = '1;
  localparam logic [CNT_W-1:0] CAP_V     = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] CLEAR_V   = CNT_W'(CAPACITY - HYST);

  if (HYST < 0 || HYST > CAPACITY || ALARM_HALF < 1) begin : g_param_check
    $error("weight_monitor: illegal HYST or ALARM_HALF");
  end

  logic            inc_pulse, dec_pulse;
  logic            clear;
  logic [CNT_W-1:0] count_q, next_count;
  weight_state_t   state_q, next_state;
  logic            near_q;

  assign clear = weight_flip_reset;

  rise_detect u_inc_detect (
    .clk          (clk),
    .button_reset (button_reset),
    .clear        (clear),
    .in           (weight_inc),
    .pulse        (inc_pulse)
  );

  rise_detect u_dec_detect (
    .clk          (clk),
    .button_reset (button_reset),
    .clear        (clear),
    .in           (weight_dec),
    .pulse        (dec_pulse)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns every variable; no latches.
    next_count = count_q;
    if (door) begin
      if (inc_pulse && !dec_pulse && count_q != MAX_COUNT)
        next_count = count_q + 1'b1;
      else if (dec_pulse && !inc_pulse && count_q != '0)
        next_count = count_q - 1'b1;
    end
  end

  // Flags follow next_count so they land on the same edge as the count.
  always_comb begin
    next_state = state_q;
    unique case (state_q)
      NORMAL:   if (next_count > CAP_V)    next_state = OVERLOAD;
      OVERLOAD: if (next_count <= CLEAR_V) next_state = NORMAL;
      default:  next_state = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (button_reset || clear) state_q <= NORMAL;
    else                       state_q <= next_state;
  end

  always_ff @(posedge clk) begin
    if (button_reset || clear) begin
      count_q <= '0;
      near_q  <= 1'b0;
    end else begin
      count_q <= next_count;
      near_q  <= (next_count == CAP_V);
    end
  end

  assign load_count            = count_q;
  assign near_full             = near_q;
  assign weight_limit_exceeded = (state_q == OVERLOAD);
  assign door_hold             = (state_q == OVERLOAD);

`ifdef WEIGHT_ALARM_EN
  localparam int AW = (ALARM_HALF > 1) ? $clog2(ALARM_HALF) : 1;
  localparam logic [AW-1:0] HALF_LAST = AW'(ALARM_HALF - 1);

  logic [AW-1:0] blink_q;
  logic          alarm_q;

  // Entry edge starts the alarm high; each ALARM_HALF-cycle phase then flips.
  always_ff @(posedge clk) begin
    if (button_reset || clear || next_state == NORMAL) begin
      blink_q <= '0;
      alarm_q <= 1'b0;
    end else if (state_q == NORMAL) begin
      blink_q <= '0;
      alarm_q <= 1'b1;
    end else if (blink_q == HALF_LAST) begin
      blink_q <= '0;
      alarm_q <= ~alarm_q;
    end else begin
      blink_q <= blink_q + 1'b1;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_weight_monitor.sv
// Randomised and directed bench for weight_monitor: a default instance and a
// narrow CNT_W=3 instance share stimulus and are compared to an arithmetic model.
module tb_weight_monitor;
  import weight_pkg::*;

  localparam int CAP = DEF_CAPACITY;
  localparam int HY  = DEF_HYST;
  localparam int AH  = DEF_ALARM_HALF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic button_reset = 1'b0, door = 1'b0, weight_inc = 1'b0, weight_dec = 1'b0;
  logic weight_flip_reset = 1'b0;

  logic [7:0] lc0;
  logic [2:0] lc1;
  logic nf0, nf1, wle0, wle1, dh0, dh1, al0, al1;

  weight_monitor dut (
    .clk (clk), .button_reset (button_reset), .door (door),
    .weight_inc (weight_inc), .weight_dec (weight_dec),
    .weight_flip_reset (weight_flip_reset),
    .load_count (lc0), .near_full (nf0), .weight_limit_exceeded (wle0),
    .door_hold (dh0), .alarm (al0)
  );

  weight_monitor #(.CNT_W(3)) dut_small (
    .clk (clk), .button_reset (button_reset), .door (door),
    .weight_inc (weight_inc), .weight_dec (weight_dec),
    .weight_flip_reset (weight_flip_reset),
    .load_count (lc1), .near_full (nf1), .weight_limit_exceeded (wle1),
    .door_hold (dh1), .alarm (al1)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: count is clamped arithmetic, alarm phase from cycles in overload.
  int m_cnt[2];
  bit m_ov[2];
  int m_idx[2];
  bit m_near[2];
  int m_max[2] = '{255, 7};
  bit p_inc, p_dec;

  task automatic model_update(input bit br, fl, dr, ic, dc);
    int ri, rd, v;
    bit was_ov;
    if (br || fl) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_ov[i] = 0; m_idx[i] = 0; m_near[i] = 0;
      end
      p_inc = 0; p_dec = 0;
    end else begin
      ri = (ic && !p_inc) ? 1 : 0;
      rd = (dc && !p_dec) ? 1 : 0;
      p_inc = ic; p_dec = dc;
      for (int i = 0; i < 2; i++) begin
        if (dr) begin
          v = m_cnt[i] + ri - rd;
          if (v < 0) v = 0;
          if (v > m_max[i]) v = m_max[i];
          m_cnt[i] = v;
        end
        was_ov = m_ov[i];
        if (!m_ov[i] && m_cnt[i] > CAP) m_ov[i] = 1;
        else if (m_ov[i] && m_cnt[i] <= CAP - HY) m_ov[i] = 0;
        m_idx[i] = (m_ov[i] && was_ov) ? m_idx[i] + 1 : 0;
        m_near[i] = (m_cnt[i] == CAP);
      end
    end
  endtask

  function automatic bit exp_alarm(int i);
`ifdef WEIGHT_ALARM_EN
    return m_ov[i] && (((m_idx[i] / AH) % 2) == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic compare_all();
    check("count0", 32'(lc0), 32'(m_cnt[0]));
    check("count1", 32'(lc1), 32'(m_cnt[1]));
    check("near0", 32'(nf0), 32'(m_near[0]));
    check("near1", 32'(nf1), 32'(m_near[1]));
    check("ovf0", 32'(wle0), 32'(m_ov[0]));
    check("ovf1", 32'(wle1), 32'(m_ov[1]));
    check("hold0", 32'(dh0), 32'(m_ov[0]));
    check("hold1", 32'(dh1), 32'(m_ov[1]));
    check("alarm0", 32'(al0), 32'(exp_alarm(0)));
    check("alarm1", 32'(al1), 32'(exp_alarm(1)));
  endtask

  task automatic step(input bit br, fl, dr, ic, dc);
    @(negedge clk);
    button_reset = br; weight_flip_reset = fl; door = dr;
    weight_inc = ic; weight_dec = dc;
    @(posedge clk);
    #1;
    model_update(br, fl, dr, ic, dc);
    compare_all();
  endtask

  task automatic inc_pulses(input int n, input bit dr);
    for (int k = 0; k < n; k++) begin
      step(0, 0, dr, 1, 0);
      step(0, 0, dr, 0, 0);
    end
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_count", 32'(lc0), 0);
    check("rst_flags", {28'd0, nf0, wle0, dh0, al0}, 0);

    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 1, 1, 0);
      check($sformatf("basic_cnt%0d", k), 32'(lc0), 32'(k));
      check($sformatf("basic_near%0d", k), 32'(nf0), 32'(k == 5));
      check($sformatf("basic_ovf%0d", k), 32'(wle0), 32'(k == 6));
      check($sformatf("basic_hold%0d", k), 32'(dh0), 32'(k == 6));
      step(0, 0, 1, 0, 0);
    end

    step(0, 0, 1, 0, 1);
    check("hyst_5_cnt", 32'(lc0), 5);
    check("hyst_5_ovf", 32'(wle0), 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    check("hyst_4_cnt", 32'(lc0), 4);
    check("hyst_4_ovf", 32'(wle0), 0);
    check("hyst_4_alarm", 32'(al0), 0);
    step(0, 0, 1, 0, 0);

    step(0, 1, 1, 0, 0);
    inc_pulses(3, 0);
    check("gated_cnt", 32'(lc0), 0);
    for (int k = 0; k < 10; k++) step(0, 0, 1, 1, 0);
    check("level_hold_cnt", 32'(lc0), 1);
    step(0, 0, 1, 0, 0);

    inc_pulses(2, 1);
    step(0, 0, 1, 1, 1);
    check("simul_cnt", 32'(lc0), 3);
    step(0, 0, 1, 0, 0);

    step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    check("dec_at_zero", 32'(lc0), 0);
    step(0, 0, 1, 0, 0);

    inc_pulses(9, 1);
    for (int k = 0; k < 10; k++) step(0, 0, 1, 0, 0);
    check("sat_small", 32'(lc1), 7);
    check("sat_small_ovf", 32'(wle1), 1);
    check("nine_default", 32'(lc0), 9);
    step(0, 1, 1, 0, 0);
    check("flip_cnt", 32'(lc1), 0);
    check("flip_flags", {29'd0, wle1, dh1, al1}, 0);

    step(0, 0, 1, 0, 0);
    step(1, 0, 1, 1, 0);
    check("rst_with_inc", 32'(lc0), 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 79) == 0,
           $urandom_range(0, 9) != 0, $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
